// File: rtl/mips_data_mem.sv
`default_nettype none
// ============================================================================
//  Module      : mips_data_mem
//  Description : Word-addressed data memory for the MIPS core memory stage.
//                A req/listo handshake with a programmable wait-state counter
//                models slow memory so the core's stall logic can be exercised.
//  Ports       :
//    clk        in   1   system clock, rising edge
//    rst        in   1   synchronous active-high reset
//    req        in   1   access request, sampled only while idle
//    we         in   1   1 = store, 0 = load (sampled with req)
//    direccion  in   32  byte address; word index = direccion[ADDR_W+1:2]
//    palabra    in   32  store data (sampled with req)
//    leer_dato  out  32  load data; valid with listo, then held
//    listo      out  1   one-cycle completion pulse
//    error      out  1   pulses with listo when the access was rejected
//    ocupado    out  1   high whenever an access is in flight
//  Revision    : 1.0  initial release
// ============================================================================
module mips_data_mem #(
    parameter int ADDR_W      = 6,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] direccion,
    input  logic [31:0] palabra,
    output logic [31:0] leer_dato,
    output logic        listo,
    output logic        error,
    output logic        ocupado
);

    localparam int         c_DEPTH   = 1 << ADDR_W;
    localparam logic [3:0] c_WAIT    = 4'(WAIT_CYCLES);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_mem [c_DEPTH];

    logic              w_accept;
    logic              w_complete;
    logic              w_misaligned;
    logic              w_out_of_range;
    logic              w_bad;
    logic [ADDR_W-1:0] w_idx;

    // Address checks act on the latched address so the core may move its
    // inputs while the access is still waiting.
    assign w_idx          = r_addr[ADDR_W+1:2];
    assign w_misaligned   = (r_addr[1:0] != 2'b00);
    assign w_out_of_range = ((r_addr >> (ADDR_W + 2)) != 32'd0);
    assign w_bad          = w_misaligned || w_out_of_range;

    assign w_accept   = (r_state == c_ST_IDLE) && req;
    assign w_complete = (r_state == c_ST_BUSY) && (r_cnt == 4'd0);

    assign ocupado    = (r_state != c_ST_IDLE);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (req) w_state_nxt = c_ST_BUSY;
            c_ST_BUSY: if (r_cnt == 4'd0) w_state_nxt = c_ST_DONE;
            c_ST_DONE: w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture, wait counter and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= 4'd0;
            r_we      <= 1'b0;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            leer_dato <= 32'd0;
            listo     <= 1'b0;
            error     <= 1'b0;
        end else begin
            // listo/error are high exactly while the FSM sits in DONE.
            listo <= w_complete;
            error <= w_complete && w_bad;

            if (w_accept) begin
                r_we    <= we;
                r_addr  <= direccion;
                r_wdata <= palabra;
                r_cnt   <= c_WAIT;
            end else if ((r_state == c_ST_BUSY) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            // Rejected accesses of either kind zero the read data; a good
            // store leaves the last load result untouched.
            if (w_complete) begin
                if (w_bad) begin
                    leer_dato <= 32'd0;
                end else if (!r_we) begin
                    leer_dato <= r_mem[w_idx];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage array: never cleared, so contents survive rst. A reset that
    // lands on the completing edge aborts the write.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst && w_complete && r_we && !w_bad) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_data_mem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_data_mem
//  Description : Self-checking bench for mips_data_mem with a behavioural
//                memory model and randomized traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mips_data_mem;

    localparam int ADDR_W = 6;
    localparam int W      = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [31:0] direccion;
    logic [31:0] palabra;
    logic [31:0] leer_dato;
    logic        listo;
    logic        error;
    logic        ocupado;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: array contents plus the last value the read port holds.
    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_rd;

    always #5 clk = ~clk;

    mips_data_mem #(
        .ADDR_W      (ADDR_W),
        .WAIT_CYCLES (W)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .direccion (direccion),
        .palabra   (palabra),
        .leer_dato (leer_dato),
        .listo     (listo),
        .error     (error),
        .ocupado   (ocupado)
    );

    // Apply one access to the model; returns the expected read data and error.
    function automatic void model_apply(input logic w, input logic [31:0] a,
                                        input logic [31:0] d,
                                        output logic [31:0] erd, output logic eerr);
        logic bad;
        int   idx;
        bad = (a % 4 != 0) || (a >= 32'(DEPTH * 4));
        idx = int'(a / 4) % DEPTH;
        if (bad) begin
            model_rd = 32'd0;
            eerr     = 1'b1;
        end else begin
            eerr = 1'b0;
            if (w) model_mem[idx] = d;
            else   model_rd = model_mem[idx];
        end
        erd = model_rd;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'($urandom_range(0, DEPTH - 1)) * 4;
        case ($urandom_range(0, 7))
            0:       a = a + 32'($urandom_range(1, 3));
            1:       a = a + (32'($urandom_range(1, 1000)) * 32'(DEPTH * 4));
            default: a = a;
        endcase
        return a;
    endfunction

    // Single access driver: presents the request for one edge, scrambles the
    // inputs afterwards, then waits (bounded) for listo and one more edge.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic er, output int lat,
                          output logic busy_seen, output logic pulse_one);
        @(negedge clk);
        req = 1'b1; we = w; direccion = a; palabra = d;
        @(posedge clk); #1;
        req = 1'b0; we = ~w; direccion = ~a; palabra = ~d;
        busy_seen = ocupado;
        lat = -1; rd = 32'd0; er = 1'b0; pulse_one = 1'b0;
        for (int i = 0; i <= 20; i++) begin
            if (listo) begin
                lat = i; rd = leer_dato; er = error;
                break;
            end
            @(posedge clk); #1;
        end
        if (lat >= 0) begin
            @(posedge clk); #1;
            pulse_one = !listo && !ocupado;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; req = 1'b0; we = 1'b0; direccion = 32'd0; palabra = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (leer_dato !== 32'd0) begin n_fail++; $display("FAIL reset_leer_dato: got %h expected %h", leer_dato, 32'd0); end
        n_tests++; if (listo !== 1'b0) begin n_fail++; $display("FAIL reset_listo: got %b expected 0", listo); end
        n_tests++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b expected 0", error); end
        n_tests++; if (ocupado !== 1'b0) begin n_fail++; $display("FAIL reset_ocupado: got %b expected 0", ocupado); end
        model_rd = 32'd0;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_fill;
        logic [31:0] rd, erd, d; logic er, eerr, bs, po; int lat;
        for (int i = 0; i < DEPTH; i++) begin
            d = $urandom;
            access(1'b1, 32'(i * 4), d, rd, er, lat, bs, po);
            model_apply(1'b1, 32'(i * 4), d, erd, eerr);
            n_tests++;
            if (lat !== W + 1 || er !== eerr || rd !== erd || !bs || !po) begin
                n_fail++;
                $display("FAIL fill[%0d]: got lat=%0d err=%b rd=%h busy=%b pulse=%b expected lat=%0d err=%b rd=%h busy=1 pulse=1",
                         i, lat, er, rd, bs, po, W + 1, eerr, erd);
            end
        end
    endtask

    task automatic test_store_load;
        logic [31:0] rd, erd; logic er, eerr, bs, po; int lat;
        access(1'b1, 32'h8, 32'hDEADBEEF, rd, er, lat, bs, po);
        model_apply(1'b1, 32'h8, 32'hDEADBEEF, erd, eerr);
        n_tests++; if (lat !== W + 1) begin n_fail++; $display("FAIL store_latency: got %0d expected %0d", lat, W + 1); end
        n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL store_error: got %b expected 0", er); end
        access(1'b0, 32'h8, 32'h0, rd, er, lat, bs, po);
        model_apply(1'b0, 32'h8, 32'h0, erd, eerr);
        n_tests++; if (lat !== W + 1) begin n_fail++; $display("FAIL load_latency: got %0d expected %0d", lat, W + 1); end
        n_tests++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_data: got %h expected %h", rd, 32'hDEADBEEF); end
        n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL load_error: got %b expected 0", er); end
        n_tests++; if (!po) begin n_fail++; $display("FAIL load_pulse_width: got listo/ocupado still high, expected low"); end
    endtask

    task automatic test_misaligned;
        logic [31:0] rd, erd; logic er, eerr, bs, po; int lat;
        access(1'b1, 32'h6, 32'hCAFEF00D, rd, er, lat, bs, po);
        model_apply(1'b1, 32'h6, 32'hCAFEF00D, erd, eerr);
        n_tests++; if (lat !== W + 1) begin n_fail++; $display("FAIL misaligned_latency: got %0d expected %0d", lat, W + 1); end
        n_tests++; if (er !== 1'b1) begin n_fail++; $display("FAIL misaligned_error: got %b expected 1", er); end
        n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL misaligned_leer_dato: got %h expected 0", rd); end
        access(1'b0, 32'h4, 32'h0, rd, er, lat, bs, po);
        model_apply(1'b0, 32'h4, 32'h0, erd, eerr);
        n_tests++; if (rd !== erd) begin n_fail++; $display("FAIL misaligned_mem1_unchanged: got %h expected %h", rd, erd); end
        n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL misaligned_followup_error: got %b expected 0", er); end
    endtask

    task automatic test_out_of_range;
        logic [31:0] rd, erd; logic er, eerr, bs, po; int lat;
        access(1'b0, 32'h100, 32'h0, rd, er, lat, bs, po);
        model_apply(1'b0, 32'h100, 32'h0, erd, eerr);
        n_tests++; if (lat !== W + 1) begin n_fail++; $display("FAIL oor_latency: got %0d expected %0d", lat, W + 1); end
        n_tests++; if (er !== 1'b1) begin n_fail++; $display("FAIL oor_error: got %b expected 1", er); end
        n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL oor_leer_dato: got %h expected 0", rd); end
    endtask

    task automatic test_abort;
        logic [31:0] rd, erd; logic er, eerr, bs, po; int lat; int seen;
        @(negedge clk);
        req = 1'b1; we = 1'b1; direccion = 32'h4; palabra = 32'h12345678;
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (ocupado !== 1'b0) begin n_fail++; $display("FAIL abort_ocupado: got %b expected 0", ocupado); end
        @(negedge clk); rst = 1'b0;
        model_rd = 32'd0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (listo) seen++;
        end
        n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL abort_no_listo: got %0d pulses expected 0", seen); end
        n_tests++; if (leer_dato !== 32'd0) begin n_fail++; $display("FAIL abort_leer_dato: got %h expected 0", leer_dato); end
        access(1'b0, 32'h4, 32'h0, rd, er, lat, bs, po);
        model_apply(1'b0, 32'h4, 32'h0, erd, eerr);
        n_tests++; if (rd !== erd) begin n_fail++; $display("FAIL abort_prior_value: got %h expected %h", rd, erd); end
    endtask

    // req held high for several accesses; inputs are scrambled and then moved
    // to the next operation while each access is still busy.
    task automatic test_held;
        logic        hw [6];
        logic [31:0] ha [6];
        logic [31:0] hd [6];
        logic [31:0] erd; logic eerr;
        int k, ph;
        for (int i = 0; i < 6; i++) begin
            hw[i] = 1'($urandom);
            ha[i] = rand_addr();
            hd[i] = $urandom;
        end
        hw[0] = 1'b1; ha[0] = 32'h20; hd[0] = 32'hA5A5_0001;
        hw[1] = 1'b0; ha[1] = 32'h20;
        @(negedge clk);
        req = 1'b1; we = hw[0]; direccion = ha[0]; palabra = hd[0];
        for (int t = 0; t < 30; t++) begin
            @(posedge clk); #1;
            k  = t / 5;
            ph = t % 5;
            n_tests++;
            if (ocupado !== (ph != 4)) begin n_fail++; $display("FAIL held_ocupado[t=%0d]: got %b expected %b", t, ocupado, (ph != 4)); end
            n_tests++;
            if (listo !== (ph == 3)) begin n_fail++; $display("FAIL held_listo[t=%0d]: got %b expected %b", t, listo, (ph == 3)); end
            if (ph == 3) begin
                model_apply(hw[k], ha[k], hd[k], erd, eerr);
                n_tests++;
                if (leer_dato !== erd || error !== eerr) begin
                    n_fail++;
                    $display("FAIL held_data[%0d]: got rd=%h err=%b expected rd=%h err=%b", k, leer_dato, error, erd, eerr);
                end
            end
            if (ph == 1) begin
                we = 1'($urandom); direccion = $urandom; palabra = $urandom;
            end
            if (ph == 2) begin
                if (k < 5) begin
                    we = hw[k+1]; direccion = ha[k+1]; palabra = hd[k+1];
                end else begin
                    req = 1'b0;
                end
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] rd, erd, a, d; logic w, er, eerr, bs, po; int lat;
        for (int i = 0; i < 40; i++) begin
            w = 1'($urandom);
            a = rand_addr();
            d = $urandom;
            access(w, a, d, rd, er, lat, bs, po);
            model_apply(w, a, d, erd, eerr);
            n_tests++;
            if (lat !== W + 1 || er !== eerr || rd !== erd || !bs || !po) begin
                n_fail++;
                $display("FAIL random[%0d] we=%b addr=%h: got lat=%0d err=%b rd=%h busy=%b pulse=%b expected lat=%0d err=%b rd=%h",
                         i, w, a, lat, er, rd, bs, po, W + 1, eerr, erd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_store_load();
        test_misaligned();
        test_out_of_range();
        test_abort();
        test_held();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
